// File: rtl/exception_sequencer.sv
// Exception sequencer: captures EPC/cause on overflow or invalid opcode, flushes the
// pipeline, redirects to the handler vector, waits for RFE and resumes at EPC+1.
module exception_sequencer #(
  parameter int              PC_W         = 16,
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [PC_W-1:0] VECTOR_ADDR  = 16'h0040
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_en,
  input  logic            ovf_evt,
  input  logic            badop_evt,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] id_pc,
  input  logic            rfe,
  output logic            flush_all,
  output logic            pc_hold,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_load_val,
  output logic [PC_W-1:0] epc,
  output logic [1:0]      cause,
  output logic            exc_busy,
  output logic            double_fault
);

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_REDIRECT, S_HANDLER, S_RETURN
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PC_W-1:0]   epc_nxt, load_val_nxt;
  logic [1:0]        cause_nxt;
  logic              df_nxt, evt;

  assign evt = exc_en & (ovf_evt | badop_evt);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    epc_nxt      = epc;
    cause_nxt    = cause;
    df_nxt       = double_fault;
    load_val_nxt = '0;
    case (state)
      S_IDLE: if (evt) begin
        // overflow belongs to the older (EX) instruction, so it wins
        state_nxt = S_FLUSH;
        cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
        epc_nxt   = ovf_evt ? ex_pc : id_pc;
        cause_nxt = ovf_evt ? 2'b01 : 2'b10;
      end
      S_FLUSH: begin
        if (cnt == '0) state_nxt = S_REDIRECT;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_REDIRECT: state_nxt = S_HANDLER;
      S_HANDLER: begin
        if (evt) df_nxt    = 1'b1;
        if (rfe) state_nxt = S_RETURN;
      end
      S_RETURN: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_REDIRECT)    load_val_nxt = VECTOR_ADDR;
    else if (state_nxt == S_RETURN) load_val_nxt = epc_nxt + PC_W'(1);
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      epc          <= '0;
      cause        <= 2'b00;
      double_fault <= 1'b0;
      flush_all    <= 1'b0;
      pc_hold      <= 1'b0;
      pc_load      <= 1'b0;
      pc_load_val  <= '0;
      exc_busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      epc          <= epc_nxt;
      cause        <= cause_nxt;
      double_fault <= df_nxt;
      flush_all    <= (state_nxt == S_FLUSH);
      pc_hold      <= (state_nxt == S_FLUSH);
      pc_load      <= (state_nxt == S_REDIRECT) || (state_nxt == S_RETURN);
      pc_load_val  <= load_val_nxt;
      exc_busy     <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Randomized scoreboard bench for exception_sequencer: a cycle-count reference model
// pushes expected outputs each edge; a negedge monitor pops and compares.
module tb_exception_sequencer;
  localparam int FC = 2;
  localparam logic [15:0] VEC = 16'h0040;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        exc_en = 1'b0, ovf_evt = 1'b0, badop_evt = 1'b0, rfe = 1'b0;
  logic [15:0] ex_pc = '0, id_pc = '0;
  logic        flush_all, pc_hold, pc_load, exc_busy, double_fault;
  logic [15:0] pc_load_val, epc;
  logic [1:0]  cause;

  int checks = 0, errors = 0;

  exception_sequencer #(.PC_W(16), .FLUSH_CYCLES(FC), .VECTOR_ADDR(VEC)) dut (
    .clk(clk), .rst_n(rst_n), .exc_en(exc_en), .ovf_evt(ovf_evt), .badop_evt(badop_evt),
    .ex_pc(ex_pc), .id_pc(id_pc), .rfe(rfe), .flush_all(flush_all), .pc_hold(pc_hold),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .epc(epc), .cause(cause),
    .exc_busy(exc_busy), .double_fault(double_fault));

  always #5 clk = ~clk;

  typedef struct {
    logic        flush, load, busy, df;
    logic [15:0] val, epc;
    logic [1:0]  cause;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Reference model: t counts edges since the trigger; flush spans t=1..FC,
  // redirect is t=FC+1, anything later is the handler until rfe starts the return cycle.
  bit          m_active = 0, m_ret = 0, m_df = 0;
  int          m_t = 0;
  logic [15:0] m_epc = '0;
  logic [1:0]  m_cause = '0;
  always @(posedge clk) begin
    exp_t e;
    bit evt;
    if (!rst_n) begin
      m_active = 0; m_ret = 0; m_df = 0; m_t = 0; m_epc = '0; m_cause = '0;
    end else begin
      evt = exc_en && (ovf_evt || badop_evt);
      if (!m_active) begin
        if (evt) begin
          m_active = 1; m_t = 1;
          m_epc   = ovf_evt ? ex_pc : id_pc;
          m_cause = ovf_evt ? 2'd1 : 2'd2;
        end
      end else if (m_t <= FC + 1) m_t++;
      else if (m_ret) begin m_active = 0; m_ret = 0; end
      else begin
        if (evt) m_df = 1;
        if (rfe) m_ret = 1;
      end
    end
    e.flush = m_active && m_t <= FC;
    e.load  = m_active && (m_t == FC + 1 || m_ret);
    e.val   = m_ret ? m_epc + 16'd1 : VEC;
    e.busy  = m_active;
    e.df    = m_df;
    e.epc   = m_epc;
    e.cause = m_cause;
    q.push_back(e);
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("flush_all", 16'(flush_all), 16'(e.flush));
      chk("pc_hold", 16'(pc_hold), 16'(e.flush));
      chk("pc_load", 16'(pc_load), 16'(e.load));
      if (e.load) chk("pc_load_val", pc_load_val, e.val);
      chk("exc_busy", 16'(exc_busy), 16'(e.busy));
      chk("double_fault", 16'(double_fault), 16'(e.df));
      chk("epc", epc, e.epc);
      chk("cause", 16'(cause), 16'(e.cause));
    end
  end

  task automatic step(input logic en, input logic ov, input logic bo,
                      input logic [15:0] xp, input logic [15:0] ip, input logic rf);
    @(negedge clk); #1;
    exc_en = en; ovf_evt = ov; badop_evt = bo; ex_pc = xp; id_pc = ip; rfe = rf;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic async_reset();
    rst_n = 1'b0; #1;
    chk("rst flush_all", 16'(flush_all), 16'd0);
    chk("rst pc_load", 16'(pc_load), 16'd0);
    chk("rst exc_busy", 16'(exc_busy), 16'd0);
    chk("rst double_fault", 16'(double_fault), 16'd0);
    chk("rst epc", epc, 16'd0);
    chk("rst cause", 16'(cause), 16'd0);
    chk("rst pc_load_val", pc_load_val, 16'd0);
  endtask

  initial begin
    async_reset();
    idle(3);
    @(negedge clk); #1; rst_n = 1'b1;
    idle(2);
    // overflow, then return
    step(1, 1, 0, 16'h0123, 16'h0456, 0); idle(5); step(1, 0, 0, 0, 0, 1); idle(3);
    // simultaneous events, then double fault in handler (also with rfe same cycle later)
    step(1, 1, 1, 16'h0010, 16'h0011, 0); idle(5);
    step(1, 0, 1, 16'h0999, 16'h0aaa, 0); idle(2); step(1, 1, 0, 0, 0, 1); idle(3);
    // epc wrap on return
    step(1, 1, 0, 16'hFFFF, 16'h0000, 0); idle(5); step(1, 0, 0, 0, 0, 1); idle(3);
    // disabled events ignored
    for (int i = 0; i < 5; i++) step(0, 1, 1, 16'h1234, 16'h5678, 0);
    // reset in second flush cycle
    step(1, 0, 1, 16'h0, 16'h0777, 0); idle(1);
    @(negedge clk); #2; async_reset();
    @(negedge clk); #1; rst_n = 1'b1;
    idle(6);
    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) begin
        @(negedge clk); #2; async_reset();
        @(negedge clk); #1; rst_n = 1'b1;
      end else begin
        step($urandom_range(99) < 85, $urandom_range(99) < 12, $urandom_range(99) < 12,
             ($urandom_range(5) == 0) ? 16'hFFFF : 16'($urandom),
             ($urandom_range(5) == 0) ? 16'hFFFF : 16'($urandom),
             $urandom_range(99) < 15);
      end
    end
    idle(4);
    @(negedge clk); #2;
    chk("queue drained", 16'(q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
